// File: rtl/port_debounce.sv
// Multi-channel pin conditioner: synchroniser, shared sample-tick prescaler,
// per-channel stability counter and one-cycle rise/fall event pulses.
module port_debounce #(
  parameter int               WIDTH        = 8,
  parameter int               STABLE_COUNT = 4,
  parameter int               TICK_DIV     = 1,
  parameter int               SYNC_STAGES  = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] pin_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_edge_o
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_COUNT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [PW-1:0]    r_presc;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_pin;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  logic             w_tick;
  logic [WIDTH-1:0] w_sync_last;
  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_pin_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= RESET_VALUE;
    end else begin
      r_sync[0] <= pin_i;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync_last = r_sync[SYNC_STAGES-1];

  // With TICK_DIV=1 P_LAST is 0, so the prescaler stays at 0 and ticks every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                r_presc <= '0;
    else if (r_presc == P_LAST) r_presc <= '0;
    else                       r_presc <= r_presc + 1'b1;
  end

  assign w_tick = (r_presc == P_LAST);

  always_comb begin
    w_pin_nxt  = r_pin;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int n = 0; n < WIDTH; n++) w_cnt_nxt[n] = r_cnt[n];
    if (w_tick) begin
      for (int n = 0; n < WIDTH; n++) begin
        if (w_sync_last[n] == r_pin[n]) begin
          w_cnt_nxt[n] = '0;
        end else if (r_cnt[n] == C_LAST) begin
          w_cnt_nxt[n]  = '0;
          w_pin_nxt[n]  = w_sync_last[n];
          w_rise_nxt[n] = w_sync_last[n];
          w_fall_nxt[n] = ~w_sync_last[n];
        end else begin
          w_cnt_nxt[n] = r_cnt[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < WIDTH; n++) r_cnt[n] <= '0;
      r_pin  <= RESET_VALUE;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      for (int n = 0; n < WIDTH; n++) r_cnt[n] <= w_cnt_nxt[n];
      r_pin  <= w_pin_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign pin_o      = r_pin;
  assign rise_o     = r_rise;
  assign fall_o     = r_fall;
  assign any_edge_o = |(r_rise | r_fall);

endmodule

// File: tb/tb_port_debounce.sv
// Scoreboard bench for port_debounce: a default instance and a TICK_DIV=4 instance
// share stimulus and are checked every cycle against a sample-window reference model.
module tb_port_debounce;

  localparam int SC  = 4;
  localparam int SS  = 2;
  localparam int TD0 = 1;
  localparam int TD1 = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pin_i = 8'h00;

  logic [7:0] p0, r0, f0, p1, r1, f1;
  logic       a0, a1;

  always #5 clock = ~clock;

  port_debounce dut0 (
    .clock(clock), .reset(reset), .pin_i(pin_i),
    .pin_o(p0), .rise_o(r0), .fall_o(f0), .any_edge_o(a0)
  );

  port_debounce #(.TICK_DIV(TD1)) dut1 (
    .clock(clock), .reset(reset), .pin_i(pin_i),
    .pin_o(p1), .rise_o(r1), .fall_o(f1), .any_edge_o(a1)
  );

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] f;
    logic       a;
  } exp_t;

  exp_t       sb    [2][$];
  logic [7:0] msync [2][$];
  logic [7:0] mwin  [2][$];
  logic [7:0] mpin  [2];
  int         medge [2];

  int n_checks = 0;
  int n_errors = 0;

  int rcnt [8];
  int fcnt [8];
  int a1cyc;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int tdiv(int u);
    return (u == 0) ? TD0 : TD1;
  endfunction

  task automatic model_reset(int u);
    sb[u].delete();
    msync[u].delete();
    for (int s = 0; s < SS; s++) msync[u].push_back(8'h00);
    mwin[u].delete();
    mpin[u]  = 8'h00;
    medge[u] = 0;
  endtask

  // Output follows a channel once the last SC tick samples all disagree with it.
  task automatic model_step(int u, logic [7:0] pin);
    logic [7:0] cur, r, f;
    bit all_diff;
    cur = msync[u].pop_front();
    msync[u].push_back(pin);
    r = 8'h00;
    f = 8'h00;
    if (medge[u] % tdiv(u) == tdiv(u) - 1) begin
      mwin[u].push_back(cur);
      if (mwin[u].size() > SC) void'(mwin[u].pop_front());
      if (mwin[u].size() == SC) begin
        for (int n = 0; n < 8; n++) begin
          all_diff = 1'b1;
          for (int k = 0; k < mwin[u].size(); k++)
            if (mwin[u][k][n] == mpin[u][n]) all_diff = 1'b0;
          if (all_diff) begin
            mpin[u][n] = ~mpin[u][n];
            if (mpin[u][n]) r[n] = 1'b1;
            else            f[n] = 1'b1;
          end
        end
      end
    end
    medge[u]++;
    sb[u].push_back(exp_t'{mpin[u], r, f, |(r | f)});
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, pin_i);
      model_step(1, pin_i);
    end
  end

  always @(negedge clock) begin : monitor
    exp_t e, g;
    for (int u = 0; u < 2; u++) begin
      g = (u == 0) ? exp_t'{p0, r0, f0, a0} : exp_t'{p1, r1, f1, a1};
      if (!reset || sb[u].size() == 0) e = exp_t'{8'h00, 8'h00, 8'h00, 1'b0};
      else                             e = sb[u].pop_front();
      check($sformatf("out%0d", u), 32'(g), 32'(e));
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
    for (int n = 0; n < 8; n++) begin
      rcnt[n] += int'(r0[n]);
      fcnt[n] += int'(f0[n]);
    end
    if (a1) a1cyc++;
    #1;
  endtask

  task automatic hold(logic [7:0] v, int n);
    pin_i = v;
    repeat (n) cycle();
  endtask

  task automatic clr();
    for (int n = 0; n < 8; n++) begin
      rcnt[n] = 0;
      fcnt[n] = 0;
    end
    a1cyc = 0;
  endtask

  task automatic wait_pin(int u, int ch, logic v, output int lat);
    logic [7:0] pv;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      cycle();
      pv = (u == 0) ? p0 : p1;
      if (pv[ch] == v) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    logic [7:0] v;
    model_reset(0);
    model_reset(1);
    clr();

    // reset held with a pin already high, then released
    pin_i = 8'h01;
    reset = 1'b0;
    repeat (3) cycle();
    check("reset_out0", {p0, r0, f0, 7'h0, a0}, 32'h0);
    check("reset_out1", {p1, r1, f1, 7'h0, a1}, 32'h0);
    reset = 1'b1;
    wait_pin(0, 0, 1'b1, lat);
    check("lat_after_reset", lat, 6);
    check("rise_at_update", r0, 8'h01);
    check("any_at_update", a0, 1'b1);
    cycle();
    check("rise_one_cycle", r0, 8'h00);
    hold(8'h01, 40);
    check("rise0_count", rcnt[0], 1);

    // 3-cycle glitch must be filtered by both instances
    clr();
    hold(8'h03, 3);
    hold(8'h01, 40);
    check("glitch_pin", p0[1], 1'b0);
    check("glitch_pulses", rcnt[1] + fcnt[1], 0);
    check("glitch_td4_events", a1cyc, 0);

    // bounce, then hold
    clr();
    hold(8'h05, 1);
    hold(8'h01, 1);
    hold(8'h05, 1);
    hold(8'h01, 1);
    pin_i = 8'h05;
    wait_pin(0, 2, 1'b1, lat);
    check("lat_after_bounce", lat, 6);
    hold(8'h05, 40);
    check("bounce_rise_count", rcnt[2], 1);
    check("bounce_fall_count", fcnt[2], 0);

    // all channels together, prescaled latency window
    hold(8'h00, 40);
    clr();
    pin_i = 8'hFF;
    wait_pin(1, 7, 1'b1, lat);
    check("lat_td4_in_window", (lat >= 15 && lat <= 18), 1'b1);
    hold(8'hFF, 30);
    check("all_rise_pin", p0, 8'hFF);
    check("all_rise_pin_td4", p1, 8'hFF);
    for (int n = 0; n < 8; n++) check($sformatf("all_rise_cnt%0d", n), rcnt[n], 1);
    check("td4_pulse_width", a1cyc, 1);
    clr();
    hold(8'h0F, 40);
    check("fall_pin", p0, 8'h0F);
    check("fall_pin_td4", p1, 8'h0F);
    for (int n = 0; n < 8; n++) check($sformatf("fall_cnt%0d", n), fcnt[n], (n >= 4) ? 1 : 0);
    check("td4_fall_width", a1cyc, 1);

    // reset in the middle of a count
    hold(8'h00, 40);
    clr();
    pin_i = 8'h08;
    repeat (4) cycle();
    reset = 1'b0;
    #1;
    check("midreset_pin", p0, 8'h00);
    #1;
    cycle();
    reset = 1'b1;
    wait_pin(0, 3, 1'b1, lat);
    check("lat_after_midreset", lat, 6);
    hold(8'h08, 40);
    check("midreset_rise_count", rcnt[3], 1);

    // randomized phase with occasional resets
    repeat (150) begin
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        repeat ($urandom_range(1, 2)) cycle();
        reset = 1'b1;
      end
      v = pin_i ^ (8'($urandom) & 8'($urandom));
      hold(v, $urandom_range(1, 14));
    end
    hold(pin_i, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
